// File: rtl/rr_grant_scheduler.sv
// Registered 8-way round-robin scheduler: one owner at a time, tenure ends on
// done, request drop or hold-limit timeout; grant is one-hot decoded from the owner index.
module rr_grant_scheduler #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic             HoldEn   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             to_q, to_d;
    logic [7:0]       gnt_q, gnt_d;

    logic             owner_req;
    logic             at_limit;
    logic             rel;

    // First requester at or after start, wrapping mod 8.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign owner_req = req[idx_q];
    assign at_limit  = HoldEn && (cnt_q == HoldLast);
    assign rel       = done || !owner_req || at_limit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        to_d    = 1'b0;

        if (!en) begin
            if (state_q == StGrant) begin
                ptr_d = idx_q + 3'd1;
            end
            state_d = StIdle;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        idx_d   = pick(req, ptr_q);
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StGrant;
                    end
                end
                StGrant: begin
                    if (rel) begin
                        ptr_d = idx_q + 3'd1;
                        // Pulse only when the limit alone ended the tenure.
                        to_d  = at_limit && !done && owner_req;
                        cnt_d = '0;
                        if (|req) begin
                            idx_d = pick(req, idx_q + 3'd1);
                        end else begin
                            valid_d = 1'b0;
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end

        gnt_d = valid_d ? (8'b1 << idx_d) : 8'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler: a tenure-level reference model predicts
// each cycle's outputs into a queue; a monitor pops and compares after every edge.
module tb_rr_grant_scheduler;

    localparam int unsigned MaxHold = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_grant_scheduler #(
        .MAX_HOLD(MaxHold),
        .CNT_W   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: owner (-1 = none), priority pointer, cycles held so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_last  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    function automatic int winner(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_last  = 0;
        exp_q.delete();
    endtask

    // Drive inputs for the coming edge and predict the outputs after it.
    task automatic drive(input logic e, input logic [7:0] r, input logic d);
        exp_t x;
        logic to;
        logic limit;
        int   w;
        en   = e;
        req  = r;
        done = d;
        to   = 1'b0;
        if (!e) begin
            if (m_owner >= 0) m_ptr = (m_owner + 1) % 8;
            m_owner = -1;
        end else if (m_owner < 0) begin
            w = winner(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
            end
        end else begin
            limit = (MaxHold != 0) && (m_held == int'(MaxHold));
            if (d || !r[m_owner] || limit) begin
                to      = limit && !d && r[m_owner];
                m_ptr   = (m_owner + 1) % 8;
                m_owner = winner(r, m_ptr);
                m_held  = 1;
            end else begin
                m_held++;
            end
        end
        if (m_owner >= 0) m_last = m_owner;
        x.valid = (m_owner >= 0);
        x.gnt   = x.valid ? (8'h01 << m_last) : 8'h00;
        x.idx   = 3'(m_last);
        x.to    = to;
        exp_q.push_back(x);
    endtask

    task automatic cycle(input logic e, input logic [7:0] r, input logic d);
        @(negedge clk);
        drive(e, r, d);
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt", 32'(gnt), 32'(e.gnt));
                check("gnt_idx", 32'(gnt_idx), 32'(e.idx));
                check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
                check("timeout", 32'(timeout), 32'(e.to));
            end
        end
    end

    initial begin : stimulus
        logic [7:0] r;
        #2;
        rst_n = 1'b0;
        #1;
        check("init_gnt", 32'(gnt), 32'h0);
        check("init_valid", 32'(gnt_valid), 32'h0);
        check("init_timeout", 32'(timeout), 32'h0);
        check("init_idx", 32'(gnt_idx), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        // Two requesters, done hands over back-to-back.
        cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b1, 8'h05, 1'b1);
        cycle(1'b1, 8'h05, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Full rotation with wrap.
        async_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'hFF, (i != 0));

        // Sole requester hits the hold limit and is re-granted with timeout.
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'h08, 1'b0);
        cycle(1'b1, 8'h08, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);

        // Owner 5 drops its request, requester 1 takes over, then all drop.
        async_reset();
        cycle(1'b1, 8'h20, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h00, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);

        // en low during tenure of 6 moves ptr to 7; then 0 wins over 6.
        async_reset();
        cycle(1'b1, 8'h40, 1'b0);
        cycle(1'b1, 8'h40, 1'b0);
        cycle(1'b0, 8'h40, 1'b0);
        cycle(1'b1, 8'h41, 1'b0);
        cycle(1'b1, 8'h41, 1'b0);

        // en low together with the hold limit.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h41, 1'b0);
        cycle(1'b0, 8'h41, 1'b0);

        // Mid-tenure reset, then requester 7 only.
        cycle(1'b1, 8'h18, 1'b0);
        cycle(1'b1, 8'h18, 1'b0);
        async_reset();
        cycle(1'b1, 8'h80, 1'b0);
        cycle(1'b1, 8'h80, 1'b0);

        // Randomised traffic.
        r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0, 1: r = 8'($urandom());
                2:    r = 8'h01 << $urandom_range(0, 7);
                default: ;
            endcase
            cycle(($urandom_range(0, 15) != 0), r, ($urandom_range(0, 4) == 0));
        end
        cycle(1'b0, 8'h00, 1'b0);

        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
